// File: rtl/block_edit_pkg.sv
// Shared types and constants for the block edit controller.
// Grid geometry, FSM states and word-memory address width.
package block_edit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        COMMIT_RD,
        COMMIT_WR
    } state_t;

    localparam int BLOCK_LOG2 = 5;
    localparam int GRID_COLS  = 20;
    localparam int GRID_ROWS  = 15;

    localparam logic [9:0] H_RES = 10'd640;
    localparam logic [8:0] V_RES = 9'd480;

    localparam int WR_ADDR_W = 14;

    localparam logic [4:0] ROW_LAST = 5'd31;

endpackage

// File: rtl/block_edit_ctrl_if.sv
// Word-memory write port: valid/ready request with address and row data.
// master: controller drives valid/addr/data; slave: memory drives ready.
interface block_edit_ctrl_if;
    import block_edit_pkg::*;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [WR_ADDR_W-1:0] wr_addr;
    logic [31:0]          wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/block_edit_ctrl_btn_edge_det.sv
// Rising-edge detector for one mouse button level.
// Ports: clk, rst_n, btn (level in), rise (one-cycle edge out).
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    // hist = {previous, current}
    logic [1:0] hist;
    logic       armed;

    // The first sample after reset seeds both history bits so a
    // button held through reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= 2'b00;
            armed <= 1'b0;
        end else begin
            hist  <= armed ? {hist[0], btn} : {btn, btn};
            armed <= 1'b1;
        end
    end

    assign rise = hist[0] & ~hist[1];

endmodule

// File: rtl/block_edit_ctrl.sv
// Block edit controller: selects a grid block on left click, clears
// the canvas, and on commit copies 32 canvas rows to word memory.
// Ports: clk/rst_n, mouse position/buttons, key_enter/key_esc,
// editing/writing_block_pos/canvas_clear to the pixel path,
// canvas_rd_row/canvas_rd_data canvas read, wr write port (master),
// commit_done pulse and busy.
module block_edit_ctrl
    import block_edit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  mouse_x,
    input  logic [8:0]  mouse_y,
    input  logic        mouse_left,
    input  logic        mouse_right,
    input  logic        key_enter,
    input  logic        key_esc,
    output logic        editing,
    output logic [8:0]  writing_block_pos,
    output logic        canvas_clear,
    output logic [4:0]  canvas_rd_row,
    input  logic [31:0] canvas_rd_data,
    block_edit_ctrl_if.master wr,
    output logic        commit_done,
    output logic        busy
);

    state_t      state;
    logic [4:0]  row;
    logic        wr_valid_q;
    logic        wr_first;
    logic [31:0] wr_data_q;
    logic        left_rise;
    logic        right_rise;
    logic        on_grid;

    btn_edge_det u_left (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (mouse_left),
        .rise  (left_rise)
    );

    btn_edge_det u_right (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (mouse_right),
        .rise  (right_rise)
    );

    assign on_grid = (mouse_x < H_RES) && (mouse_y < V_RES);

    assign canvas_rd_row = row;
    assign wr.wr_valid   = wr_valid_q;
    assign wr.wr_addr    = {writing_block_pos, row};

    // Canvas read data lands in the first write cycle; present it
    // directly then, and the held copy while waiting for ready.
    assign wr.wr_data = wr_first ? canvas_rd_data : wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            row               <= '0;
            editing           <= 1'b0;
            writing_block_pos <= '0;
            canvas_clear      <= 1'b0;
            commit_done       <= 1'b0;
            busy              <= 1'b0;
            wr_valid_q        <= 1'b0;
            wr_first          <= 1'b0;
            wr_data_q         <= '0;
        end else begin
            canvas_clear <= 1'b0;
            commit_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (left_rise && on_grid) begin
                        writing_block_pos <= {
                            mouse_y[8:BLOCK_LOG2],
                            mouse_x[9:BLOCK_LOG2]
                        };
                        canvas_clear <= 1'b1;
                        editing      <= 1'b1;
                        state        <= EDIT;
                    end
                end
                EDIT: begin
                    if (key_esc || right_rise) begin
                        editing <= 1'b0;
                        state   <= IDLE;
                    end else if (key_enter) begin
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= COMMIT_RD;
                    end
                end
                COMMIT_RD: begin
                    wr_valid_q <= 1'b1;
                    wr_first   <= 1'b1;
                    state      <= COMMIT_WR;
                end
                COMMIT_WR: begin
                    wr_first <= 1'b0;
                    if (wr_first) begin
                        wr_data_q <= canvas_rd_data;
                    end
                    if (wr.wr_ready) begin
                        wr_valid_q <= 1'b0;
                        if (row == ROW_LAST) begin
                            row         <= '0;
                            commit_done <= 1'b1;
                            editing     <= 1'b0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            row   <= row + 5'd1;
                            state <= COMMIT_RD;
                        end
                    end
                end
                default: begin
                    editing    <= 1'b0;
                    busy       <= 1'b0;
                    wr_valid_q <= 1'b0;
                    wr_first   <= 1'b0;
                    row        <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/block_edit_ctrl.md
Name: block_edit_ctrl

Overview:
Edit-mode controller for the 20x15 grid of 32x32 character blocks on the 640x480 display.
- Selects the block under the mouse on left click and drives `editing` / `writing_block_pos` to the pixel generator.
- Clears the drawing canvas on entry.
- On commit, copies the 32 canvas rows into glyph/word memory through a valid/ready write port.

Parameters:
GRID_COLS, 20, number of block columns (640/32)
GRID_ROWS, 15, number of block rows (480/32)
H_RES, 640, horizontal active pixels; mouse_x >= H_RES is off-grid
V_RES, 480, vertical active pixels; mouse_y >= V_RES is off-grid

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mouse_x  in  10  mouse X pixel position
mouse_y  in  9  mouse Y pixel position
mouse_left  in  1  left button level
mouse_right  in  1  right button level
key_enter  in  1  one-cycle commit request pulse
key_esc  in  1  one-cycle cancel request pulse
editing  out  1  block edit in progress (EDIT or COMMIT)
writing_block_pos  out  9  {row[3:0], col[4:0]} of selected block
canvas_clear  out  1  one-cycle canvas clear pulse
canvas_rd_row  out  5  canvas row index; data returns 1 cycle later
canvas_rd_data  in  32  canvas row pixels, bit i = column i
wr_valid  out  1  word-memory write request
wr_ready  in  1  word-memory accepts write when wr_valid & wr_ready
wr_addr  out  14  {writing_block_pos, row[4:0]}
wr_data  out  32  row pixels
commit_done  out  1  one-cycle pulse after final row accepted
busy  out  1  high in COMMIT_RD/COMMIT_WR

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including writing_block_pos, row counter and button history registers.
- Button edges: mouse_left and mouse_right are registered once. A rising edge is current=1 & previous=0, so an edge acts the cycle after the button goes high. A button held through reset release produces no edge.
- IDLE:
  - Left edge with mouse_x<H_RES and mouse_y<V_RES: latch writing_block_pos={mouse_y[8:5], mouse_x[9:5]}, pulse canvas_clear, enter EDIT.
  - Off-grid click: ignored.
  - key_enter / key_esc / right edge: ignored.
- EDIT:
  - editing=1. Left edges are ignored; drawing belongs to the canvas.
  - key_esc or right edge: go to IDLE, editing=0, nothing written.
  - key_enter: go to COMMIT_RD with row=0.
  - Cancel and key_enter in the same cycle: cancel wins.
- COMMIT_RD (1 cycle): canvas_rd_row=row. Next state COMMIT_WR.
- COMMIT_WR:
  - Capture canvas_rd_data into wr_data on entry.
  - Assert wr_valid with wr_addr={writing_block_pos,row}.
  - wr_valid, wr_addr and wr_data stay stable until wr_ready.
  - On accept, row<31: row+1, go to COMMIT_RD, wr_valid=0 for that cycle.
  - On accept, row==31: pulse commit_done, go to IDLE, editing=0.
- Commit latency: with wr_ready tied high, 64 cycles from the key_enter cycle to the commit_done pulse.
- During commit: all keys and mouse edges are ignored and the commit cannot be cancelled. writing_block_pos is frozen and editing stays 1.
- Commit completion with a left click in the same cycle: the click is ignored. It is only seen as a new edge if it occurs in IDLE.
- Reset mid-commit: write aborted immediately. Word memory may hold a partial block; this is accepted.
- Unknown or illegal state encodings go to IDLE.

Decomposition:
- Shared package block_edit_pkg:
  - state enum (IDLE, EDIT, COMMIT_RD, COMMIT_WR)
  - BLOCK_LOG2=5
  - grid/resolution constants
  - WR_ADDR_W=14
- One sub-module, btn_edge_det: a 2-bit register plus rising-edge output, instantiated for each mouse button.

Test Plan:
- Reset, then left click at (100,70) -> writing_block_pos=9'h043, canvas_clear one pulse, editing=1.
- Click at (639,479) -> pos={4'd14,5'd19}=9'h1D3. Click at (640,10) -> ignored, editing stays 0.
- In EDIT, key_enter and key_esc in the same cycle -> IDLE, editing=0, no wr_valid ever asserted.
- Commit of block 9'h043 with wr_ready=1, canvas row r returning 32'h0000_0001<<r:
  - 32 writes, addresses 14'h0860..14'h087F, data matching each row.
  - commit_done exactly 64 cycles after key_enter.
- Commit with wr_ready low for 5 cycles at row 7 -> wr_addr/wr_data held stable, no skipped or duplicated rows, commit_done delayed by 5 cycles.
- Assert rst_n=0 at row 10 of a commit -> all outputs 0 immediately. A following left click starts a fresh selection.
